dmem_pipe: RTL and testbench
============================

Name: dmem_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle word data memory used by the MIPS32 FP/DSP datapath.
- Adds configurable width, depth and read latency, byte-lane write strobes, a valid/ready request port, out-of-range error reporting, and a post-reset clear sweep.
- Sits between the MEM stage and the FP/integer register write-back.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- DEPTH, 32, number of words; power of two, at least 2.
- READ_LAT, 1, cycles from request acceptance to read response; at least 1.
- BYTE_ADDR, 0, 0 = req_addr is a word index; 1 = req_addr is a byte address and the low log2(DATA_W/8) bits are dropped.
- CLEAR_ON_RST, 1, 1 = zero every word after reset; 0 = contents retained across reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  address, interpreted per BYTE_ADDR
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte-lane write enables
- rsp_valid  out  1  read response valid, one-cycle pulse
- rsp_rdata  out  DATA_W  read data; 0 when rsp_valid=0
- rsp_err  out  1  response error, qualified by rsp_valid

Behaviour:
- Clock and reset: clk is the single clock. rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. The read pipeline is flushed and the FSM enters INIT.
- State machine, two states:
  - INIT: with CLEAR_ON_RST=1, a counter writes 0 to word 0..DEPTH-1, one word per cycle, then moves to IDLE; INIT lasts DEPTH cycles. With CLEAR_ON_RST=0, INIT lasts 1 cycle. req_ready=0 throughout INIT.
  - IDLE: req_ready=1 every cycle. There is no backpressure on the response side; the consumer must always accept.
- Accept: a request is accepted on a cycle where req_valid and req_ready are both 1.
- Word index: idx = addr_w[AW-1:0], where AW = log2(DEPTH).
- Out of range: if addr_w has any bit at or above AW set, the request is out of range.
- Writes: array update on the accept edge, only for lanes where req_wstrb[i]=1.
  - All-zero strobe is a legal no-op.
  - Out-of-range writes are dropped silently; no response is produced.
- Reads: rsp_valid pulses exactly READ_LAT cycles after the accept edge.
  - rsp_rdata is the word as it was at the accept edge.
  - Out-of-range read: rsp_rdata=0, rsp_err=1.
- Back-to-back: one request per cycle, full throughput. Reads in flight complete in order.
  - A read accepted the cycle after a write to the same idx returns the new data.
  - Write and read never coincide, since there is one request port.
- Reset mid-operation: in-flight responses are discarded (rsp_valid=0 from the next edge) and the clear sweep restarts from word 0.
- Writes arriving during INIT are not accepted, because req_ready=0.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - One even-parity bit per byte is stored alongside the data and rewritten on every strobed write and by the clear sweep.
  - On read, the parity is recomputed. Any mismatch sets rsp_err=1; the data is still returned.
  - Adds input par_inj (1 bit). While par_inj=1, parity bits written by an accepted write are inverted, for test.
- Not defined: no parity storage, no par_inj port, and rsp_err reflects out-of-range only.

Decomposition:
- Shared package dmem_pkg:
  - FSM state enum {ST_INIT, ST_IDLE}.
  - Function byte_parity(); localparam helpers for the strobe width and the address shift.
- Sub-module dmem_rd_pipe: READ_LAT-deep valid/data/err shift register with synchronous flush; instantiated once.

Test Plan:
- Reset with CLEAR_ON_RST=1, DEPTH=32 -> req_ready=0 for 32 cycles then 1; reading words 0..31 returns 0 with rsp_err=0.
- Write idx 5 = 0x400D7A04 with wstrb=4'hF, then read idx 5 the next cycle, READ_LAT=3 -> rsp_valid exactly 3 cycles after the read accept, rdata=0x400D7A04.
- Write 0x11223344 with wstrb=4'hF, then write 0xAABBCCDD with wstrb=4'b0101, then read -> 0x11BB33DD.
- BYTE_ADDR=1, DEPTH=32, read addr 0x80 -> rsp_err=1, rdata=0. Write to 0x80 -> no word changes (full sweep readback compared against a model).
- Issue 4 back-to-back reads, then assert rst one cycle after the last accept -> no rsp_valid after reset; the INIT sweep restarts.
- With DMEM_PARITY_EN: write 0x3F800000 with par_inj=1, then read -> rsp_err=1, rdata=0x3F800000. Rewrite with par_inj=0 -> rsp_err=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory (dmem_pipe).
// The package carries the FSM state encoding, the per-byte parity function and width helpers.
package dmem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    // Even parity: the stored bit makes the total count of ones in byte+bit even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int addr_shift(input int data_w, input int byte_addr);
        return (byte_addr != 0) ? $clog2(data_w / 8) : 0;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Read response pipeline: READ_LAT-deep valid/data/err shift register with synchronous flush.
// Stage 0 is aligned with the memory's registered read output; data and error are merged there.
module dmem_rd_pipe #(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_oor,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic              in_perr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err
);

    logic              s0_valid_reg;
    logic              s0_oor_reg;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_err;
    logic              tail_valid;
    logic [DATA_W-1:0] tail_data;
    logic              tail_err;

    always_ff @(posedge clk) begin
        if (flush) begin
            s0_valid_reg <= 1'b0;
        end else begin
            s0_valid_reg <= in_valid;
        end
        s0_oor_reg <= in_oor;
    end

    // Out-of-range reads must return zero regardless of what the aliased word holds.
    assign m_valid = s0_valid_reg;
    assign m_data  = s0_oor_reg ? '0 : in_rdata;
    assign m_err   = s0_oor_reg | in_perr;

    generate
        if (READ_LAT == 1) begin : g_direct
            assign tail_valid = m_valid;
            assign tail_data  = m_data;
            assign tail_err   = m_err;
        end else begin : g_sr
            logic              v_reg [READ_LAT-1];
            logic [DATA_W-1:0] d_reg [READ_LAT-1];
            logic              e_reg [READ_LAT-1];

            always_ff @(posedge clk) begin
                if (flush) begin
                    for (int k = 0; k < READ_LAT - 1; k++) begin
                        v_reg[k] <= 1'b0;
                    end
                end else begin
                    v_reg[0] <= m_valid;
                    for (int k = 1; k < READ_LAT - 1; k++) begin
                        v_reg[k] <= v_reg[k-1];
                    end
                end
                d_reg[0] <= m_data;
                e_reg[0] <= m_err;
                for (int k = 1; k < READ_LAT - 1; k++) begin
                    d_reg[k] <= d_reg[k-1];
                    e_reg[k] <= e_reg[k-1];
                end
            end

            assign tail_valid = v_reg[READ_LAT-2];
            assign tail_data  = d_reg[READ_LAT-2];
            assign tail_err   = e_reg[READ_LAT-2];
        end
    endgenerate

    assign out_valid = tail_valid;
    assign out_rdata = tail_valid ? tail_data : '0;
    assign out_err   = tail_valid & tail_err;

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined word data memory with byte strobes, range checking and a post-reset clear sweep.
// Optional per-byte even parity with error injection when DMEM_PARITY_EN is defined.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 32,
    parameter int READ_LAT     = 1,
    parameter int BYTE_ADDR    = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
`ifdef DMEM_PARITY_EN
    input  logic                par_inj,
`endif
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NB     = strb_w(DATA_W);
    localparam int AW     = $clog2(DEPTH);
    localparam int ASHIFT = addr_shift(DATA_W, BYTE_ADDR);

    state_t            state_reg, state_next;
    logic [AW-1:0]     clr_cnt_reg, clr_cnt_next;
    logic              clr_active;

    logic [31:0]       addr_w;
    logic [AW-1:0]     idx;
    logic              oor;
    logic              acc;
    logic              rd_en;

    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_strb;
    logic [DATA_W-1:0] ram_q;
    logic [NB-1:0]     perr_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_INIT;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (CLEAR_ON_RST == 0 || clr_cnt_reg == AW'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
                if (CLEAR_ON_RST != 0) begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            ST_IDLE: state_next = ST_IDLE;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        clr_active = 1'b0;
        case (state_reg)
            ST_INIT: clr_active = (CLEAR_ON_RST != 0);
            ST_IDLE: req_ready  = 1'b1;
            default: req_ready  = 1'b0;
        endcase
    end

    assign addr_w = req_addr >> ASHIFT;
    assign idx    = addr_w[AW-1:0];
    assign oor    = |addr_w[31:AW];
    assign acc    = req_valid & req_ready & ~rst;
    assign rd_en  = acc & ~req_we;

    // The clear sweep and accepted writes share the single array write port.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_data = req_wdata;
        wr_strb = req_wstrb;
        if (clr_active) begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_reg;
            wr_data = '0;
            wr_strb = '1;
        end else if (acc && req_we && !oor) begin
            wr_en   = 1'b1;
        end
    end

`ifdef DMEM_PARITY_EN
    logic wr_inj;
    assign wr_inj = par_inj & ~clr_active;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_strb[gi]) begin
                    lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                end
                if (rd_en) begin
                    q_reg <= lane_mem[idx];
                end
            end

            assign ram_q[gi*8 +: 8] = q_reg;

`ifdef DMEM_PARITY_EN
            logic par_mem [DEPTH];
            logic par_q_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_strb[gi]) begin
                    par_mem[wr_idx] <= byte_parity(wr_data[gi*8 +: 8]) ^ wr_inj;
                end
                if (rd_en) begin
                    par_q_reg <= par_mem[idx];
                end
            end

            assign perr_lane[gi] = byte_parity(q_reg) ^ par_q_reg;
`else
            assign perr_lane[gi] = 1'b0;
`endif
        end
    endgenerate

    dmem_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .flush     (rst),
        .in_valid  (rd_en),
        .in_oor    (oor),
        .in_rdata  (ram_q),
        .in_perr   (|perr_lane),
        .out_valid (rsp_valid),
        .out_rdata (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: DEPTH=32, READ_LAT=3, byte addressing, clear on reset.
// Define DMEM_PARITY_EN to also exercise the parity injection path.
module tb_dmem_pipe;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
`ifdef DMEM_PARITY_EN
    logic        par_inj;
`endif
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_pipe #(
        .DATA_W       (DW),
        .DEPTH        (DEPTH),
        .READ_LAT     (LAT),
        .BYTE_ADDR    (1),
        .CLEAR_ON_RST (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
`ifdef DMEM_PARITY_EN
        .par_inj   (par_inj),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          t;
        string       tag;
    } exp_t;

    exp_t        exq[$];
    exp_t        cur;
    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: every response is matched in order against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid === 1'b1) begin
                if (exq.size() == 0) begin
                    check("rsp_valid with empty queue", 32'(rsp_valid), 32'd0);
                end else begin
                    cur = exq.pop_front();
                    check({cur.tag, " data"}, rsp_rdata, cur.d);
                    check({cur.tag, " err"}, 32'(rsp_err), 32'(cur.e));
                    check({cur.tag, " cycle"}, 32'(cyc), 32'(cur.t));
                    $display("rsp %-22s rdata=0x%08h err=%0b cyc=%0d", cur.tag, rsp_rdata, rsp_err, cyc);
                end
            end else if (rsp_rdata !== 32'd0) begin
                check("rdata while not valid", rsp_rdata, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) check("req_ready timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        w = int'(a >> 2);
        if ((a >> 2) < DEPTH) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model[w][i*8 +: 8] = d[i*8 +: 8];
            end
        end
        $display("wr  addr=0x%08h data=0x%08h strb=%04b", a, d, s);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d_exp, input logic e_exp, input string tag);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        exq.push_back('{d: d_exp, e: e_exp, t: cyc + LAT, tag: tag});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        int n;
        rst = 1'b1;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        rst = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, " init cycles"}, 32'(n), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        $display("reset %s: INIT lasted %0d cycles", tag, n);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_wstrb = 4'd0;
`ifdef DMEM_PARITY_EN
        par_inj   = 1'b0;
`endif
        @(negedge clk);
        do_reset("power-on");

        for (int i = 0; i < DEPTH; i++) rd(32'(i * 4), 32'd0, 1'b0, $sformatf("clear w%0d", i));

        wr(32'h14, 32'h400D7A04, 4'hF);
        rd(32'h14, 32'h400D7A04, 1'b0, "raw idx5");

        wr(32'h20, 32'h11223344, 4'hF);
        wr(32'h20, 32'hAABBCCDD, 4'b0101);
        rd(32'h20, 32'h11BB33DD, 1'b0, "strobe merge");
        wr(32'h20, 32'hFFFFFFFF, 4'b0000);
        rd(32'h20, 32'h11BB33DD, 1'b0, "zero strobe");
        rd(32'h17, 32'h400D7A04, 1'b0, "byte offset dropped");

`ifdef DMEM_PARITY_EN
        par_inj = 1'b1;
        wr(32'h30, 32'h3F800000, 4'hF);
        par_inj = 1'b0;
        rd(32'h30, 32'h3F800000, 1'b1, "parity injected");
        wr(32'h30, 32'h3F800000, 4'hF);
        rd(32'h30, 32'h3F800000, 1'b0, "parity clean");
`endif

        rd(32'h80, 32'd0, 1'b1, "oor 0x80");
        rd(32'hFFFFFFFC, 32'd0, 1'b1, "oor top");
        wr(32'h80, 32'hDEADBEEF, 4'hF);
        wr(32'h7C, 32'hCAFEF00D, 4'hF);
        wr(32'h00, 32'h000000A5, 4'b0001);
        wr(32'h40, 32'h12345678, 4'b1000);
        for (int i = 0; i < DEPTH; i++) rd(32'(i * 4), model[i], 1'b0, $sformatf("sweep w%0d", i));

        // Four back-to-back reads, reset one cycle after the last accept.
        rd(32'h14, model[5], 1'b0, "inflight 0");
        rd(32'h20, model[8], 1'b0, "inflight 1");
        rd(32'h7C, model[31], 1'b0, "inflight 2");
        rd(32'h00, model[0], 1'b0, "inflight 3");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in-flight reads left at reset", 32'(exq.size()), 32'd2);
        exq.delete();
        do_reset("mid-run");
        rd(32'h14, 32'd0, 1'b0, "post-reset idx5");
        rd(32'h7C, 32'd0, 1'b0, "post-reset idx31");

        n = 0;
        while (exq.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("responses outstanding at end", 32'(exq.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
